// File: rtl/pool_window_buffer.sv
// pool_window_buffer
//   Gathers non-overlapping STRIDE_SIZE x STRIDE_SIZE windows from a
//   row-major raster pixel stream. The windows feed a max-pool stage.
//
// Ports
//   clock          : single clock; all state updates on its rising edge
//   sreset_n       : asynchronous active-low reset
//   data_in        : one pixel (DATA_WIDTH bits, treated as opaque bits)
//   data_in_valid  : accepts data_in on this edge; there is no backpressure
//   window_out     : packed window; element e = r*S + c sits at
//                    [(e+1)*DATA_WIDTH-1 : e*DATA_WIDTH] (r=0 is the top row, c=0 the left column)
//   window_valid   : one-cycle qualifier for window_out; registered, latency 1
//   frame_done     : one-cycle pulse after the last pixel of a frame
module pool_window_buffer #(
  parameter int STRIDE_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ROW_SIZE    = 4,
  parameter int COLUMN_SIZE = 4
) (
  input  logic                                       clock,
  input  logic                                       sreset_n,
  input  logic [DATA_WIDTH-1:0]                      data_in,
  input  logic                                       data_in_valid,
  output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                       window_valid,
  output logic                                       frame_done
);

  localparam int S        = STRIDE_SIZE;
  localparam int COL_W    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int ROW_W    = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
  // Previous S-1 full rows plus the current row's last S-1 pixels.
  localparam int unsigned HIST_LEN = (S - 1) * ROW_SIZE + (S - 1);
  localparam int COL_LAST = (ROW_SIZE / S) * S - 1;
  localparam int ROW_LAST = (COLUMN_SIZE / S) * S - 1;

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] hist [HIST_LEN];
  logic [S*S*DATA_WIDTH-1:0] win_next;
  logic                  col_hit;
  logic                  row_hit;
  logic                  col_wrap;
  logic                  row_wrap;

  // Raster history as one shift register: hist[k] is the pixel accepted
  // k+1 pixels before the current one. Storage is deliberately not reset;
  // the counters restart at row 0 after reset, so the first window cannot
  // reach any pixel from before the reset.
  always_ff @(posedge clock) begin
    if (data_in_valid) begin
      hist[0] <= data_in;
      for (int unsigned i = 1; i < HIST_LEN; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  // Window element (r,c) lies a fixed number of pixels back from the
  // completing pixel (bottom-right, which is data_in itself).
  for (genvar r = 0; r < S; r++) begin : g_row
    for (genvar c = 0; c < S; c++) begin : g_col
      localparam int BACK = (S - 1 - r) * ROW_SIZE + (S - 1 - c);
      localparam int E    = r * S + c;
      if (BACK == 0) begin : g_cur
        assign win_next[E*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end else begin : g_hist
        assign win_next[E*DATA_WIDTH +: DATA_WIDTH] = hist[BACK-1];
      end
    end
  end

  always_comb begin
    col_hit  = ((int'(col) % S) == S - 1) && (int'(col) <= COL_LAST);
    row_hit  = ((int'(row) % S) == S - 1) && (int'(row) <= ROW_LAST);
    col_wrap = (col == COL_W'(ROW_SIZE - 1));
    row_wrap = (row == ROW_W'(COLUMN_SIZE - 1));
  end

  always_ff @(posedge clock or negedge sreset_n) begin
    if (!sreset_n) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      window_out   <= '0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (data_in_valid) begin
        if (col_hit && row_hit) begin
          window_valid <= 1'b1;
          window_out   <= win_next;
        end
        if (col_wrap) begin
          col <= '0;
          if (row_wrap) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
